wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning slow-port buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning wait cycles after which the FIFO head overrides port A.
REQ-003 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports a_valid_i in 1 / a_ready_o out 1: fast-pipe (ALU) writeback handshake.
REQ-006 SHALL have ports a_addr_i in REGFILE_WIDTH / a_data_i in 64 (bus64_t): fast-pipe destination and value.
REQ-007 SHALL have ports b_valid_i in 1 / b_ready_o out 1: slow-unit (mul/div/mem) writeback handshake.
REQ-008 SHALL have ports b_addr_i in REGFILE_WIDTH / b_data_i in 64 (bus64_t): slow-unit destination and value.
REQ-009 SHALL have ports write_enable_o out 1 / write_addr_o out REGFILE_WIDTH / write_data_o out 64: register-file write port.
REQ-010 SHALL have port b_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-011 Transfer on a port SHALL occur in a cycle where valid and ready are both 1.
REQ-012 b_ready_o SHALL be 1 iff occupancy < FIFO_DEPTH, using registered occupancy only (no combinational path from any input).
REQ-013 Accepted B entries with b_addr_i != 0 SHALL be enqueued in order; no bypass; earliest write is 2 cycles after acceptance.
REQ-014 Accepted entries with address 0 (either port) SHALL be discarded: handshake completes, no enqueue, no write.
REQ-015 Grant each cycle: FIFO head if FIFO full, or if age counter == STARVE_LIMIT; otherwise port A if a_valid_i; otherwise FIFO head if non-empty; otherwise none.
REQ-016 a_ready_o SHALL be 0 exactly when the FIFO head holds the grant by REQ-015's first two rules; otherwise 1.
REQ-017 Granted entry SHALL appear on write_enable_o/addr/data exactly 1 cycle after grant (registered output); write_enable_o=0 in cycles with no grant.
REQ-018 Age counter SHALL increment each cycle the FIFO is non-empty and head not granted, saturate at STARVE_LIMIT, clear to 0 on dequeue or when empty.
REQ-019 Enqueue and dequeue in the same cycle SHALL leave occupancy unchanged; enqueue while full cannot occur (REQ-012).
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full/empty derived from occupancy counter.
REQ-021 Ordering between A and B writes to the same register SHALL NOT be enforced; issue logic guarantees no overlap.
REQ-022 At most one register-file write SHALL be issued per cycle.

Reset
REQ-023 While rst_i=1 at a clock edge: occupancy, pointers and age counter SHALL clear to 0; write_enable_o, write_addr_o, write_data_o SHALL be 0.
REQ-024 Reset mid-operation SHALL discard all FIFO contents and any pending output write; no write issued in the cycle after reset.
REQ-025 During reset cycles a_ready_o SHALL be 1 and b_ready_o SHALL be 1 (empty FIFO); inputs accepted in those cycles SHALL be dropped.

Structure
REQ-026 REGFILE_WIDTH, bus64_t and a wb_entry_t struct {addr, data} SHALL come from drac_pkg; no local redefinition.
REQ-027 The buffer SHALL be one sub-module, wb_fifo (parameterised depth, push/pop/count), instantiated once; arbitration and output register live in wb_arbiter.

Verification
REQ-028 Reset, then A only: a_valid_i=1, a_addr_i=5, a_data_i=0x11 -> next cycle write_enable_o=1, addr 5, data 0x11; a_ready_o=1 throughout.
REQ-029 B into idle arbiter: b addr 7 data 0x22 at cycle 0 -> write addr 7 data 0x22 at cycle 2; b_count_o 1 at cycle 1, 0 at cycle 2.
REQ-030 Fill: A valid every cycle, B pushes addr 1..4 -> after 4 pushes b_ready_o=0, a_ready_o=0, addr 1 written, then A resumes; FIFO order 1,2,3,4 preserved.
REQ-031 Starvation: A valid every cycle, one B entry addr 9 -> after 8 A writes, addr 9 written with a_ready_o=0 that grant cycle; age counter back to 0.
REQ-032 x0 drop: a_addr_i=0 and b_addr_i=0 both valid -> both accepted, b_count_o stays 0, write_enable_o stays 0.
REQ-033 Reset mid-operation: 3 entries queued, assert rst_i one cycle -> b_count_o=0, no writes of queued entries ever appear.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared types for the writeback path: register index width, 64-bit bus and
// the {addr, data} entry that flows from the execution units to the register file.
package drac_pkg;

    localparam int REGFILE_WIDTH = 5;

    typedef logic [63:0]              bus64_t;
    typedef logic [REGFILE_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t addr;
        bus64_t    data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_A,
        GRANT_B
    } wb_grant_e;

    // x0 is hardwired to zero, so writes to it are dropped rather than issued.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for slow-unit writebacks. The caller guarantees that it never
// pushes while full or pops while empty; full/empty derive from the count.
module wb_fifo
    import drac_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  wb_entry_t                push_entry,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; stale contents are never visible
    // because count gates every read, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the fast pipe (A) writes directly, the slow
// units (B) go through wb_fifo; the FIFO head wins when full or starved.
module wb_arbiter
    import drac_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          a_valid_i,
    output logic                          a_ready_o,
    input  logic [REGFILE_WIDTH-1:0]      a_addr_i,
    input  bus64_t                        a_data_i,

    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    input  logic [REGFILE_WIDTH-1:0]      b_addr_i,
    input  bus64_t                        b_data_i,

    output logic                          write_enable_o,
    output logic [REGFILE_WIDTH-1:0]      write_addr_o,
    output bus64_t                        write_data_o,

    output logic [$clog2(FIFO_DEPTH):0]   b_count_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    wb_entry_t        head;
    wb_entry_t        sel_entry;
    wb_grant_e        grant;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age_q;
    logic             empty;
    logic             full;
    logic             head_force;
    logic             push;
    logic             pop;

    assign empty      = count == '0;
    assign full       = count == CNT_W'(FIFO_DEPTH);
    assign head_force = full || (!empty && age_q == AGE_W'(STARVE_LIMIT));

    // Readies depend only on registered state; reset forces them open so that
    // anything offered during reset completes its handshake and is dropped.
    assign a_ready_o = rst_i || !head_force;
    assign b_ready_o = rst_i || !full;
    assign b_count_o = count;

    assign push = !rst_i && b_valid_i && !full && !is_x0(b_addr_i);
    assign pop  = !rst_i && (grant == GRANT_B);

    // NOTE: every signal assigned here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = GRANT_NONE;
        sel_entry = head;
        if (head_force) begin
            grant = GRANT_B;
        end else if (a_valid_i) begin
            grant     = GRANT_A;
            sel_entry = '{addr: a_addr_i, data: a_data_i};
        end else if (!empty) begin
            grant = GRANT_B;
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .push_entry ('{addr: b_addr_i, data: b_data_i}),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    // Age of the FIFO head: only climbs while the head waits behind port A.
    always_ff @(posedge clk_i) begin
        if (rst_i || empty || pop) begin
            age_q <= '0;
        end else if (age_q != AGE_W'(STARVE_LIMIT)) begin
            age_q <= age_q + 1'b1;
        end
    end

    // An A grant to x0 still consumes the slot but never reaches the file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_enable_o <= 1'b0;
            write_addr_o   <= '0;
            write_data_o   <= '0;
        end else begin
            write_enable_o <= (grant != GRANT_NONE) && !is_x0(sel_entry.addr);
            if ((grant != GRANT_NONE) && !is_x0(sel_entry.addr)) begin
                write_addr_o <= sel_entry.addr;
                write_data_o <= sel_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each step drives inputs, advances one clock,
// and checks outputs 1 ns after the rising edge against hand-derived values.
module tb_wb_arbiter;
    import drac_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     a_valid_i;
    logic                     a_ready_o;
    logic [REGFILE_WIDTH-1:0] a_addr_i;
    bus64_t                   a_data_i;
    logic                     b_valid_i;
    logic                     b_ready_o;
    logic [REGFILE_WIDTH-1:0] b_addr_i;
    bus64_t                   b_data_i;
    logic                     write_enable_o;
    logic [REGFILE_WIDTH-1:0] write_addr_o;
    bus64_t                   write_data_o;
    logic [2:0]               b_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .a_valid_i      (a_valid_i),
        .a_ready_o      (a_ready_o),
        .a_addr_i       (a_addr_i),
        .a_data_i       (a_data_i),
        .b_valid_i      (b_valid_i),
        .b_ready_o      (b_ready_o),
        .b_addr_i       (b_addr_i),
        .b_data_i       (b_data_i),
        .write_enable_o (write_enable_o),
        .write_addr_o   (write_addr_o),
        .write_data_o   (write_data_o),
        .b_count_o      (b_count_o)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_write(input string tag, input logic we, input logic [63:0] addr, input logic [63:0] data);
        check({tag, ".we"}, 64'(write_enable_o), 64'(we));
        if (we) begin
            check({tag, ".addr"}, 64'(write_addr_o), addr);
            check({tag, ".data"}, write_data_o, data);
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        a_valid_i = 1'b0; a_addr_i = '0; a_data_i = '0;
        b_valid_i = 1'b0; b_addr_i = '0; b_data_i = '0;
        cyc();
        cyc();

        // Reset state
        check("rst.we",      64'(write_enable_o), 64'd0);
        check("rst.addr",    64'(write_addr_o),   64'd0);
        check("rst.data",    write_data_o,        64'd0);
        check("rst.count",   64'(b_count_o),      64'd0);
        check("rst.a_ready", 64'(a_ready_o),      64'd1);
        check("rst.b_ready", 64'(b_ready_o),      64'd1);
        rst_i = 1'b0;
        cyc();

        // A only: written the cycle after grant
        a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 64'h11;
        check("a_only.a_ready", 64'(a_ready_o), 64'd1);
        cyc();
        a_valid_i = 1'b0;
        expect_write("a_only.w", 1'b1, 64'd5, 64'h11);
        check("a_only.a_ready2", 64'(a_ready_o), 64'd1);
        cyc();
        expect_write("a_only.idle", 1'b0, 64'd0, 64'd0);

        // B into idle arbiter: write two cycles after acceptance
        b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 64'h22;
        check("b_idle.b_ready", 64'(b_ready_o), 64'd1);
        cyc();
        b_valid_i = 1'b0;
        check("b_idle.count1", 64'(b_count_o), 64'd1);
        expect_write("b_idle.c1", 1'b0, 64'd0, 64'd0);
        cyc();
        expect_write("b_idle.c2", 1'b1, 64'd7, 64'h22);
        check("b_idle.count2", 64'(b_count_o), 64'd0);
        cyc();
        expect_write("b_idle.c3", 1'b0, 64'd0, 64'd0);

        // Fill: A every cycle, B pushes 1..4
        for (int i = 0; i < 4; i++) begin
            a_valid_i = 1'b1; a_addr_i = 5'(16 + i); a_data_i = 64'(i);
            b_valid_i = 1'b1; b_addr_i = 5'(i + 1);  b_data_i = 64'h100 + 64'(i + 1);
            check("fill.a_ready", 64'(a_ready_o), 64'd1);
            check("fill.b_ready", 64'(b_ready_o), 64'd1);
            cyc();
        end
        b_valid_i = 1'b0;
        a_addr_i  = 5'd30; a_data_i = 64'h30;
        check("fill.count4",   64'(b_count_o), 64'd4);
        check("fill.b_ready0", 64'(b_ready_o), 64'd0);
        check("fill.a_ready0", 64'(a_ready_o), 64'd0);
        expect_write("fill.last_a", 1'b1, 64'd19, 64'd3);
        cyc();
        expect_write("fill.head1", 1'b1, 64'd1, 64'h101);
        check("fill.count3",  64'(b_count_o), 64'd3);
        check("fill.a_resume", 64'(a_ready_o), 64'd1);
        cyc();
        a_valid_i = 1'b0;
        expect_write("fill.a30", 1'b1, 64'd30, 64'h30);
        for (int k = 2; k <= 4; k++) begin
            cyc();
            expect_write("fill.order", 1'b1, 64'(k), 64'h100 + 64'(k));
        end
        check("fill.drained", 64'(b_count_o), 64'd0);
        cyc();
        expect_write("fill.idle", 1'b0, 64'd0, 64'd0);

        // Starvation: one B entry behind continuous A traffic
        a_valid_i = 1'b1; a_addr_i = 5'd20; a_data_i = 64'h20;
        b_valid_i = 1'b1; b_addr_i = 5'd9;  b_data_i = 64'h99;
        cyc();
        b_valid_i = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("starve.a_ready", 64'(a_ready_o), 64'd1);
            cyc();
            expect_write("starve.a_write", 1'b1, 64'd20, 64'h20);
        end
        check("starve.a_blocked", 64'(a_ready_o), 64'd0);
        check("starve.count", 64'(b_count_o), 64'd1);
        cyc();
        a_valid_i = 1'b0;
        expect_write("starve.head", 1'b1, 64'd9, 64'h99);
        check("starve.count0", 64'(b_count_o), 64'd0);
        check("starve.a_ready_back", 64'(a_ready_o), 64'd1);
        cyc();
        expect_write("starve.idle", 1'b0, 64'd0, 64'd0);

        // x0 drop on both ports
        a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 64'hdead;
        b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 64'hbeef;
        check("x0.a_ready", 64'(a_ready_o), 64'd1);
        check("x0.b_ready", 64'(b_ready_o), 64'd1);
        cyc();
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        check("x0.count", 64'(b_count_o), 64'd0);
        expect_write("x0.c1", 1'b0, 64'd0, 64'd0);
        cyc();
        check("x0.count2", 64'(b_count_o), 64'd0);
        expect_write("x0.c2", 1'b0, 64'd0, 64'd0);

        // Reset mid-operation with three entries queued behind A
        a_valid_i = 1'b1; a_addr_i = 5'd21; a_data_i = 64'h21;
        for (int i = 0; i < 3; i++) begin
            b_valid_i = 1'b1; b_addr_i = 5'(11 + i); b_data_i = 64'h200 + 64'(i);
            cyc();
        end
        check("mid_rst.count3", 64'(b_count_o), 64'd3);
        rst_i     = 1'b1;
        a_valid_i = 1'b0;
        b_valid_i = 1'b1; b_addr_i = 5'd14; b_data_i = 64'h214;
        check("mid_rst.a_ready", 64'(a_ready_o), 64'd1);
        check("mid_rst.b_ready", 64'(b_ready_o), 64'd1);
        cyc();
        rst_i     = 1'b0;
        b_valid_i = 1'b0;
        check("mid_rst.count0", 64'(b_count_o), 64'd0);
        expect_write("mid_rst.c0", 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            expect_write("mid_rst.none", 1'b0, 64'd0, 64'd0);
            check("mid_rst.count", 64'(b_count_o), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
